// File: rtl/conv_scan_sequencer.sv
// Scan sequencer for the convolution datapath: walks row x kernel-tap x pixel
// and issues counter advance strobes plus the wrap shifter's one-hot control.
module conv_scan_sequencer #(
    parameter int PIX_PER_ROW = 8,
    parameter int ROWS        = 9,
    parameter int KERNEL      = 3,
    localparam int PIX_W      = (PIX_PER_ROW > 1) ? $clog2(PIX_PER_ROW) : 1,
    localparam int ROW_W      = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic             Phi1,
    input  logic             Reset_s1_n,
    input  logic             start_s1,
    input  logic             stall_s1,
    input  logic             abort_s1,
    output logic             busy_s1,
    output logic             done_s1,
    output logic             cnt_reset_s1,
    output logic             pix_adv_s1,
    output logic             kern_adv_s1,
    output logic             wl_adv_s1,
    output logic             mem_adv_s1,
    output logic [2:0]       shiftctl_s1,
    output logic [PIX_W-1:0] pix_idx_s1,
    output logic [1:0]       kern_idx_s1,
    output logic [ROW_W-1:0] row_idx_s1
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [PIX_W-1:0] PIX_LAST  = PIX_W'(PIX_PER_ROW - 1);
    localparam logic [1:0]       KERN_LAST = 2'(KERNEL - 1);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(ROWS - 1);

    state_t           state, state_next;
    logic [PIX_W-1:0] pix, pix_next;
    logic [1:0]       kern, kern_next;
    logic [ROW_W-1:0] row, row_next;
    logic             pix_last, kern_last, row_last;

    always_ff @(posedge Phi1 or negedge Reset_s1_n) begin
        if (!Reset_s1_n) begin
            state <= IDLE;
            pix   <= '0;
            kern  <= '0;
            row   <= '0;
        end else begin
            state <= state_next;
            pix   <= pix_next;
            kern  <= kern_next;
            row   <= row_next;
        end
    end

    assign pix_last  = (pix == PIX_LAST);
    assign kern_last = (kern == KERN_LAST);
    assign row_last  = (row == ROW_LAST);

    // Strobes decode from the registered state, so reset forces them low at once.
    always_comb begin
        state_next   = state;
        pix_next     = pix;
        kern_next    = kern;
        row_next     = row;
        busy_s1      = 1'b0;
        done_s1      = 1'b0;
        cnt_reset_s1 = 1'b0;
        pix_adv_s1   = 1'b0;
        kern_adv_s1  = 1'b0;
        wl_adv_s1    = 1'b0;
        mem_adv_s1   = 1'b0;
        case (state)
            IDLE: begin
                if (start_s1) begin
                    state_next = CLEAR;
                    pix_next   = '0;
                    kern_next  = '0;
                    row_next   = '0;
                end
            end
            CLEAR: begin
                busy_s1      = 1'b1;
                cnt_reset_s1 = 1'b1;
                state_next   = abort_s1 ? IDLE : RUN;
            end
            RUN: begin
                busy_s1     = 1'b1;
                pix_adv_s1  = ~stall_s1 & ~abort_s1;
                kern_adv_s1 = pix_adv_s1 & pix_last;
                wl_adv_s1   = kern_adv_s1 & kern_last;
                mem_adv_s1  = wl_adv_s1;
                if (abort_s1) begin
                    state_next = IDLE;
                end else if (!stall_s1) begin
                    if (!pix_last) begin
                        pix_next = pix + PIX_W'(1);
                    end else if (!kern_last) begin
                        pix_next  = '0;
                        kern_next = kern + 2'd1;
                    end else if (!row_last) begin
                        pix_next  = '0;
                        kern_next = '0;
                        row_next  = row + ROW_W'(1);
                    end else begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                done_s1    = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        case (kern)
            2'd1:    shiftctl_s1 = 3'b010;
            2'd2:    shiftctl_s1 = 3'b001;
            default: shiftctl_s1 = 3'b100;
        endcase
    end

    assign pix_idx_s1  = pix;
    assign kern_idx_s1 = kern;
    assign row_idx_s1  = row;

endmodule

// File: tb/tb_conv_scan_sequencer.sv
// Self-checking bench for conv_scan_sequencer: a per-cycle vector table plus
// full-frame sequences covering stall, restart, abort, reset and a 1x1x1 frame.
module tb_conv_scan_sequencer;

    logic       Phi1;
    logic       Reset_s1_n;
    logic       start_s1, stall_s1, abort_s1;
    logic       busy_s1, done_s1, cnt_reset_s1;
    logic       pix_adv_s1, kern_adv_s1, wl_adv_s1, mem_adv_s1;
    logic [2:0] shiftctl_s1;
    logic [2:0] pix_idx_s1;
    logic [1:0] kern_idx_s1;
    logic [3:0] row_idx_s1;

    logic       t_start;
    logic       t_busy, t_done, t_cnt_reset;
    logic       t_pix_adv, t_kern_adv, t_wl_adv, t_mem_adv;
    logic [2:0] t_shiftctl;
    logic [0:0] t_pix_idx;
    logic [1:0] t_kern_idx;
    logic [0:0] t_row_idx;

    int errors = 0;
    int checks = 0;

    conv_scan_sequencer dut (
        .Phi1(Phi1), .Reset_s1_n(Reset_s1_n),
        .start_s1(start_s1), .stall_s1(stall_s1), .abort_s1(abort_s1),
        .busy_s1(busy_s1), .done_s1(done_s1), .cnt_reset_s1(cnt_reset_s1),
        .pix_adv_s1(pix_adv_s1), .kern_adv_s1(kern_adv_s1),
        .wl_adv_s1(wl_adv_s1), .mem_adv_s1(mem_adv_s1),
        .shiftctl_s1(shiftctl_s1), .pix_idx_s1(pix_idx_s1),
        .kern_idx_s1(kern_idx_s1), .row_idx_s1(row_idx_s1)
    );

    conv_scan_sequencer #(.PIX_PER_ROW(1), .ROWS(1), .KERNEL(1)) u_tiny (
        .Phi1(Phi1), .Reset_s1_n(Reset_s1_n),
        .start_s1(t_start), .stall_s1(1'b0), .abort_s1(1'b0),
        .busy_s1(t_busy), .done_s1(t_done), .cnt_reset_s1(t_cnt_reset),
        .pix_adv_s1(t_pix_adv), .kern_adv_s1(t_kern_adv),
        .wl_adv_s1(t_wl_adv), .mem_adv_s1(t_mem_adv),
        .shiftctl_s1(t_shiftctl), .pix_idx_s1(t_pix_idx),
        .kern_idx_s1(t_kern_idx), .row_idx_s1(t_row_idx)
    );

    initial begin
        Phi1 = 1'b0;
        forever #5 Phi1 = ~Phi1;
    end

    typedef struct {
        logic        start;
        logic        stall;
        logic        abort;
        logic [14:0] expect_out;
    } vec_t;

    vec_t vecs[18];

    function automatic logic [14:0] packOut(logic busy, logic done, logic cr, logic pa,
                                            logic ka, logic wa, logic ma, logic [2:0] sh,
                                            logic [2:0] pix, logic [1:0] kern);
        return {busy, done, cr, pa, ka, wa, ma, sh, pix, kern};
    endfunction

    function automatic logic [14:0] actualOut();
        return {busy_s1, done_s1, cnt_reset_s1, pix_adv_s1, kern_adv_s1, wl_adv_s1,
                mem_adv_s1, shiftctl_s1, pix_idx_s1, kern_idx_s1};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic st, input logic sl, input logic ab);
        @(negedge Phi1);
        start_s1 = st;
        stall_s1 = sl;
        abort_s1 = ab;
        #1;
    endtask

    // Frame statistics gathered by runFrame; cycle c is the interval after edge c,
    // with the start request sampled at edge 0.
    int doneRise, doneCount, crCount, crFirst;
    int paCount, kaCount, waCount, maCount;
    int patternErr, stallErr;
    logic capBusy;
    logic [2:0] capPix;
    logic [1:0] capKern;
    logic [3:0] capRow;

    task automatic runFrame(input int stallStart, input int stallLen, input int restartCycle,
                            input int abortCycle, input int captureCycle);
        int steps;
        logic [2:0] heldPix;
        doneRise = -1; doneCount = 0; crCount = 0; crFirst = -1;
        paCount = 0; kaCount = 0; waCount = 0; maCount = 0;
        patternErr = 0; stallErr = 0; steps = 0; heldPix = '0;
        capBusy = 1'b1; capPix = '0; capKern = '0; capRow = '0;
        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int c = 0; c < 235; c++) begin
            applyStimulus((c == restartCycle) || (restartCycle >= 0 && c == 217),
                          (c >= stallStart) && (c < stallStart + stallLen),
                          (c == abortCycle));
            if (cnt_reset_s1) begin
                crCount++;
                if (crFirst < 0) crFirst = c;
            end
            if (done_s1) begin
                doneCount++;
                if (doneRise < 0) doneRise = c;
            end
            if (stall_s1 && c == stallStart) heldPix = pix_idx_s1;
            if (stall_s1 && (pix_adv_s1 || kern_adv_s1 || wl_adv_s1 || mem_adv_s1 ||
                             pix_idx_s1 != heldPix)) stallErr++;
            if (pix_adv_s1) begin
                if (pix_idx_s1 != 3'(steps % 8) || kern_idx_s1 != 2'((steps / 8) % 3) ||
                    row_idx_s1 != 4'(steps / 24))
                    patternErr++;
                case ((steps / 8) % 3)
                    0: if (shiftctl_s1 != 3'b100) patternErr++;
                    1: if (shiftctl_s1 != 3'b010) patternErr++;
                    default: if (shiftctl_s1 != 3'b001) patternErr++;
                endcase
                steps++;
                paCount++;
            end
            if (kern_adv_s1) kaCount++;
            if (wl_adv_s1) waCount++;
            if (mem_adv_s1) maCount++;
            if (c == captureCycle) begin
                capBusy = busy_s1; capPix = pix_idx_s1;
                capKern = kern_idx_s1; capRow = row_idx_s1;
            end
        end
    endtask

    task automatic doReset();
        @(negedge Phi1);
        Reset_s1_n = 1'b0;
        start_s1 = 1'b0; stall_s1 = 1'b0; abort_s1 = 1'b0; t_start = 1'b0;
        repeat (2) @(negedge Phi1);
        Reset_s1_n = 1'b1;
    endtask

    initial begin
        logic [14:0] idleOut;
        int busySeen;
        Reset_s1_n = 1'b1;
        start_s1 = 1'b0; stall_s1 = 1'b0; abort_s1 = 1'b0; t_start = 1'b0;
        idleOut = packOut(0, 0, 0, 0, 0, 0, 0, 3'b100, 3'd0, 2'd0);

        vecs[0]  = '{0, 0, 0, idleOut};
        vecs[1]  = '{1, 0, 0, idleOut};
        vecs[2]  = '{0, 1, 0, packOut(1, 0, 1, 0, 0, 0, 0, 3'b100, 3'd0, 2'd0)};
        vecs[3]  = '{0, 0, 0, packOut(1, 0, 0, 1, 0, 0, 0, 3'b100, 3'd0, 2'd0)};
        vecs[4]  = '{0, 1, 0, packOut(1, 0, 0, 0, 0, 0, 0, 3'b100, 3'd1, 2'd0)};
        vecs[5]  = '{1, 0, 0, packOut(1, 0, 0, 1, 0, 0, 0, 3'b100, 3'd1, 2'd0)};
        vecs[6]  = '{0, 0, 0, packOut(1, 0, 0, 1, 0, 0, 0, 3'b100, 3'd2, 2'd0)};
        vecs[7]  = '{0, 0, 0, packOut(1, 0, 0, 1, 0, 0, 0, 3'b100, 3'd3, 2'd0)};
        vecs[8]  = '{0, 0, 0, packOut(1, 0, 0, 1, 0, 0, 0, 3'b100, 3'd4, 2'd0)};
        vecs[9]  = '{0, 0, 0, packOut(1, 0, 0, 1, 0, 0, 0, 3'b100, 3'd5, 2'd0)};
        vecs[10] = '{0, 0, 0, packOut(1, 0, 0, 1, 0, 0, 0, 3'b100, 3'd6, 2'd0)};
        vecs[11] = '{0, 0, 0, packOut(1, 0, 0, 1, 1, 0, 0, 3'b100, 3'd7, 2'd0)};
        vecs[12] = '{0, 0, 0, packOut(1, 0, 0, 1, 0, 0, 0, 3'b010, 3'd0, 2'd1)};
        vecs[13] = '{0, 1, 1, packOut(1, 0, 0, 0, 0, 0, 0, 3'b010, 3'd1, 2'd1)};
        vecs[14] = '{0, 0, 0, packOut(0, 0, 0, 0, 0, 0, 0, 3'b010, 3'd1, 2'd1)};
        vecs[15] = '{1, 0, 0, packOut(0, 0, 0, 0, 0, 0, 0, 3'b010, 3'd1, 2'd1)};
        vecs[16] = '{0, 0, 1, packOut(1, 0, 1, 0, 0, 0, 0, 3'b100, 3'd0, 2'd0)};
        vecs[17] = '{0, 0, 0, idleOut};

        doReset();
        #1;
        checkOutput("reset_state", 32'(actualOut()), 32'(idleOut));

        for (int i = 0; i < 18; i++) begin
            applyStimulus(vecs[i].start, vecs[i].stall, vecs[i].abort);
            checkOutput($sformatf("vector_%0d", i), 32'(actualOut()), 32'(vecs[i].expect_out));
        end

        // Clean frame with default geometry.
        doReset();
        runFrame(-1, 0, -1, -1, 218);
        checkOutput("clean_cnt_reset_count", 32'(crCount), 32'd1);
        checkOutput("clean_cnt_reset_cycle", 32'(crFirst), 32'd0);
        checkOutput("clean_done_rise", 32'(doneRise), 32'd217);
        checkOutput("clean_done_count", 32'(doneCount), 32'd1);
        checkOutput("clean_pix_adv_count", 32'(paCount), 32'd216);
        checkOutput("clean_kern_adv_count", 32'(kaCount), 32'd27);
        checkOutput("clean_wl_adv_count", 32'(waCount), 32'd9);
        checkOutput("clean_mem_adv_count", 32'(maCount), 32'd9);
        checkOutput("clean_index_shift_pattern", 32'(patternErr), 32'd0);
        checkOutput("clean_idle_after_done", 32'(capBusy), 32'd0);

        // Five stalled cycles where step 10 would have been taken.
        runFrame(11, 5, -1, -1, 13);
        checkOutput("stall_no_strobes_frozen", 32'(stallErr), 32'd0);
        checkOutput("stall_pix_held", 32'(capPix), 32'd2);
        checkOutput("stall_done_rise", 32'(doneRise), 32'd222);
        checkOutput("stall_pix_adv_count", 32'(paCount), 32'd216);
        checkOutput("stall_index_shift_pattern", 32'(patternErr), 32'd0);

        // Start re-pulsed mid-frame and during DONE.
        runFrame(-1, 0, 41, -1, 218);
        checkOutput("restart_done_rise", 32'(doneRise), 32'd217);
        checkOutput("restart_done_count", 32'(doneCount), 32'd1);
        checkOutput("restart_cnt_reset_count", 32'(crCount), 32'd1);
        checkOutput("restart_idle_at_218", 32'(capBusy), 32'd0);

        // Abort together with stall at step 50, then a full frame.
        runFrame(51, 1, -1, 51, 52);
        checkOutput("abort_busy_low", 32'(capBusy), 32'd0);
        checkOutput("abort_no_done", 32'(doneCount), 32'd0);
        checkOutput("abort_held_indices", 32'({capRow, capKern, capPix}),
                    32'({4'd2, 2'd0, 3'd2}));
        checkOutput("abort_pix_adv_count", 32'(paCount), 32'd50);
        runFrame(-1, 0, -1, -1, 218);
        checkOutput("after_abort_cnt_reset", 32'(crCount), 32'd1);
        checkOutput("after_abort_done_rise", 32'(doneRise), 32'd217);

        // Asynchronous reset in the middle of row 3.
        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int c = 0; c < 80; c++) applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("midrun_row_before_reset", 32'(row_idx_s1), 32'd3);
        Reset_s1_n = 1'b0;
        #1;
        checkOutput("midrun_reset_outputs", 32'({actualOut(), row_idx_s1}),
                    32'({idleOut, 4'd0}));
        @(negedge Phi1);
        Reset_s1_n = 1'b1;
        busySeen = 0;
        for (int c = 0; c < 5; c++) begin
            applyStimulus(1'b0, 1'b0, 1'b0);
            if (busy_s1 || cnt_reset_s1) busySeen++;
        end
        checkOutput("post_reset_stays_idle", 32'(busySeen), 32'd0);

        // Degenerate 1x1x1 geometry.
        @(negedge Phi1);
        t_start = 1'b1;
        @(negedge Phi1);
        t_start = 1'b0;
        #1;
        checkOutput("tiny_clear", 32'({t_busy, t_cnt_reset, t_pix_adv}), 32'(3'b110));
        @(negedge Phi1);
        #1;
        checkOutput("tiny_all_strobes", 32'({t_pix_adv, t_kern_adv, t_wl_adv, t_mem_adv, t_done}),
                    32'(5'b11110));
        @(negedge Phi1);
        #1;
        checkOutput("tiny_done", 32'({t_done, t_busy, t_pix_adv}), 32'(3'b100));
        @(negedge Phi1);
        #1;
        checkOutput("tiny_idle", 32'({t_done, t_busy}), 32'(2'b00));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
